// File: rtl/spike_event_packer.sv
// Timestamps LIF output spikes, attaches the inter-spike interval and queues the
// events in a small first-word-fall-through FIFO; also reports a windowed spike rate.
`timescale 1ns/1ps
module spike_event_packer #(
   parameter int TS_WIDTH   = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int WINDOW     = 64
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic                            spike,
   output logic [8+TS_WIDTH-1:0]           ev_data,
   output logic                            ev_valid,
   input  logic                            ev_ready,
   output logic [7:0]                      rate,
   output logic                            rate_valid,
   output logic                            overflow,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

   localparam int DATA_W = 8 + TS_WIDTH;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int WIN_W  = $clog2(WINDOW);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

   logic [TS_WIDTH-1:0] ts;
   logic [7:0]          isi_cnt;
   logic [WIN_W-1:0]    win_cnt;
   logic [7:0]          spk_cnt;

   logic [DATA_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [DATA_W-1:0]   last_pop;

   logic                push;
   logic                pop;
   logic                full;
   logic                wr_en;
   logic [7:0]          isi_sat;
   logic [7:0]          spk_sum;

   assign push     = en & spike;
   assign ev_valid = (fifo_count != '0);
   assign pop      = ev_valid & ev_ready;
   assign full     = (fifo_count == FULL_CNT);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign wr_en    = push & (~full | pop);
   assign ev_data  = ev_valid ? mem[rd_ptr] : last_pop;

   assign isi_sat  = (isi_cnt == 8'hFF) ? 8'hFF : isi_cnt + 8'd1;
   assign spk_sum  = (spike && spk_cnt != 8'hFF) ? spk_cnt + 8'd1 : spk_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts         <= '0;
         isi_cnt    <= 8'hFF;
         win_cnt    <= '0;
         spk_cnt    <= '0;
         rate       <= '0;
         rate_valid <= 1'b0;
      end else begin
         rate_valid <= 1'b0;
         if (en) begin
            ts      <= ts + TS_WIDTH'(1);
            isi_cnt <= spike ? 8'd1 : isi_sat;
            if (win_cnt == WIN_LAST) begin
               rate       <= spk_sum;
               rate_valid <= 1'b1;
               spk_cnt    <= '0;
               win_cnt    <= '0;
            end else begin
               spk_cnt    <= spk_sum;
               win_cnt    <= win_cnt + WIN_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {isi_cnt, ts};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
         last_pop   <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + PTR_W'(1);
            last_pop <= mem[rd_ptr];
         end
         case ({wr_en, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (push && full && !pop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spike_event_packer.sv
// Directed bench for spike_event_packer: vector table for FIFO behaviour plus
// hand-written sequences for rate window, enable gating and async reset.
`timescale 1ns/1ps
module tb_spike_event_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        spike = 1'b0;
   logic        ev_ready = 1'b0;
   logic [15:0] ev_data;
   logic        ev_valid;
   logic [7:0]  rate;
   logic        rate_valid;
   logic        overflow;
   logic [2:0]  fifo_count;

   int n_checks = 0;
   int n_fail   = 0;

   spike_event_packer dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .spike      (spike),
      .ev_data    (ev_data),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .rate       (rate),
      .rate_valid (rate_valid),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          do_rst;
      int          n;
      bit          en;
      bit          spike;
      bit          rdy;
      bit          exp_valid;
      logic [15:0] exp_data;
      int          exp_cnt;
      bit          exp_ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit r, int n, bit e, bit s, bit rd, bit v,
                               logic [15:0] d, int c, bit o);
      vec_t t;
      t.do_rst = r; t.n = n; t.en = e; t.spike = s; t.rdy = rd;
      t.exp_valid = v; t.exp_data = d; t.exp_cnt = c; t.exp_ovf = o;
      return t;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; spike = 1'b0; ev_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic fire(string name, logic [15:0] exp);
      spike = 1'b1;
      @(posedge clk); #1;
      spike = 1'b0;
      check({name, "_valid"}, 32'(ev_valid), 32'd1);
      check({name, "_data"}, 32'(ev_data), 32'(exp));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          pulses;
      int          idx [2];
      logic [7:0]  rt [2];
      logic [127:0] spk_map;

      // reset values
      #1;
      check("rst_valid", 32'(ev_valid), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_data", 32'(ev_data), 32'd0);
      check("rst_rate", 32'(rate), 32'd0);
      check("rst_rate_valid", 32'(rate_valid), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);

      // spikes at ts 5 and 12
      vecs.push_back(mk(1, 5, 1, 0, 0, 0, 16'h0000, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 1, 16'hFF05, 1, 0));
      vecs.push_back(mk(0, 6, 1, 0, 0, 1, 16'hFF05, 1, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 1, 16'hFF05, 2, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h070C, 1, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 0, 16'h0000, 0, 0));
      // overflow: spikes at ts 0,2,4,6,8 with no pops
      vecs.push_back(mk(1, 1, 1, 1, 0, 1, 16'hFF00, 1, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 16'hFF00, 1, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 1, 16'hFF00, 2, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 16'hFF00, 2, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 1, 16'hFF00, 3, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 16'hFF00, 3, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 1, 16'hFF00, 4, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 16'hFF00, 4, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 1, 16'hFF00, 4, 1));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0202, 3, 1));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0204, 2, 1));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0206, 1, 1));
      vecs.push_back(mk(0, 1, 1, 0, 1, 0, 16'h0000, 0, 1));
      // back-to-back fill, then push+pop while full
      vecs.push_back(mk(1, 4, 1, 1, 0, 1, 16'hFF00, 4, 0));
      vecs.push_back(mk(0, 1, 1, 1, 1, 1, 16'h0101, 4, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0102, 3, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0103, 2, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 1, 16'h0104, 1, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 0, 16'h0000, 0, 0));

      foreach (vecs[i]) begin
         if (vecs[i].do_rst) do_reset();
         en = vecs[i].en; spike = vecs[i].spike; ev_ready = vecs[i].rdy;
         repeat (vecs[i].n) @(posedge clk);
         #1;
         check($sformatf("vec%0d_valid", i), 32'(ev_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_cnt));
         check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
         if (vecs[i].exp_valid)
            check($sformatf("vec%0d_data", i), 32'(ev_data), 32'(vecs[i].exp_data));
      end

      // rate window: 10 spikes in the first window (one on cycle 63), then idle window
      do_reset();
      en = 1'b1; ev_ready = 1'b1;
      spk_map = '0;
      spk_map[3] = 1'b1;  spk_map[9] = 1'b1;  spk_map[15] = 1'b1; spk_map[20] = 1'b1;
      spk_map[27] = 1'b1; spk_map[33] = 1'b1; spk_map[40] = 1'b1; spk_map[48] = 1'b1;
      spk_map[55] = 1'b1; spk_map[63] = 1'b1;
      pulses = 0; idx[0] = -1; idx[1] = -1; rt[0] = '0; rt[1] = '0;
      for (int c = 0; c < 128; c++) begin
         spike = spk_map[c];
         @(posedge clk); #1;
         if (rate_valid) begin
            if (pulses < 2) begin
               idx[pulses] = c;
               rt[pulses]  = rate;
            end
            pulses++;
         end
      end
      spike = 1'b0;
      check("rate_pulses", 32'(pulses), 32'd2);
      check("rate_idx0", 32'(idx[0]), 32'd63);
      check("rate_val0", 32'(rt[0]), 32'd10);
      check("rate_idx1", 32'(idx[1]), 32'd127);
      check("rate_val1", 32'(rt[1]), 32'd0);

      // enable gating, ISI saturation and timestamp wrap
      do_reset();
      en = 1'b1; ev_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      fire("gate_first", 16'hFF02);
      en = 1'b0; spike = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      spike = 1'b0;
      check("gate_ignored_count", 32'(fifo_count), 32'd0);
      en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      fire("gate_after", 16'h0406);
      repeat (300) @(posedge clk);
      #1;
      fire("gate_sat_wrap", 16'hFF33);

      // async reset with queued events and overflow set
      do_reset();
      en = 1'b1; ev_ready = 1'b0; spike = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      spike = 1'b0;
      check("arst_pre_count", 32'(fifo_count), 32'd4);
      check("arst_pre_ovf", 32'(overflow), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 32'(ev_valid), 32'd0);
      check("arst_count", 32'(fifo_count), 32'd0);
      check("arst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;
      fire("arst_next", 16'hFF00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
